// File: rtl/uart_char_feeder.sv
// uart_char_feeder: 8N1 receiver with byte FIFO that replays each byte
// as a stable char with a fixed-width en pulse followed by a low gap.
module uart_char_feeder #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int EN_HOLD    = 4,
  parameter int EN_GAP     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    char,
  output logic                          en,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int OMAX = (EN_HOLD > EN_GAP) ? EN_HOLD : EN_GAP;
  localparam int OW   = $clog2(OMAX + 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    O_IDLE, O_HIGH, O_LOW
  } out_state_t;

  logic          rx_m_q, rx_m_d;
  logic          rx_s_q, rx_s_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick;

  rx_state_t     rs_q, rs_d;
  logic [3:0]    sc_q, sc_d;
  logic [2:0]    bi_q, bi_d;
  logic [7:0]    sh_q, sh_d;
  logic          ferr_q, ferr_d;
  logic          push;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, do_push;

  out_state_t    os_q, os_d;
  logic [OW-1:0] oc_q, oc_d;
  logic [7:0]    char_q, char_d;
  logic          en_q, en_d;
  logic          pop;

  // Synchroniser and free-running oversample tick divider.
  always_comb begin
    rx_m_d = rx;
    rx_s_d = rx_m_q;
    tick   = (div_q == DW'(DIV - 1));
    div_d  = tick ? '0 : div_q + 1'b1;
  end

  // Receiver: start qualification, LSB-first data, stop check.
  always_comb begin
    rs_d   = rs_q;
    sc_d   = sc_q;
    bi_d   = bi_q;
    sh_d   = sh_q;
    ferr_d = 1'b0;
    push   = 1'b0;
    unique case (rs_q)
      R_IDLE: begin
        if (tick && !rx_s_q) begin
          sc_d = '0;
          rs_d = R_START;
        end
      end
      R_START: begin
        if (tick) begin
          if (sc_q == 4'd7) begin
            if (!rx_s_q) begin
              rs_d = R_DATA;
              sc_d = '0;
              bi_d = '0;
            end else begin
              rs_d = R_IDLE;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      R_DATA: begin
        if (tick) begin
          if (sc_q == 4'd15) begin
            sc_d = '0;
            sh_d = {rx_s_q, sh_q[7:1]};
            if (bi_q == 3'd7) rs_d = R_STOP;
            else              bi_d = bi_q + 3'd1;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      R_STOP: begin
        if (tick) begin
          if (sc_q == 4'd15) begin
            if (rx_s_q) push   = 1'b1;
            else        ferr_d = 1'b1;
            rs_d = R_IDLE;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  // Output pulse shaper: pop, hold en high, then enforce the low gap.
  always_comb begin
    os_d   = os_q;
    oc_d   = oc_q;
    char_d = char_q;
    en_d   = en_q;
    pop    = 1'b0;
    unique case (os_q)
      O_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          char_d = mem_q[rd_q];
          en_d   = 1'b1;
          oc_d   = '0;
          os_d   = O_HIGH;
        end
      end
      O_HIGH: begin
        if (oc_q == OW'(EN_HOLD - 1)) begin
          en_d = 1'b0;
          oc_d = '0;
          os_d = O_LOW;
        end else begin
          oc_d = oc_q + 1'b1;
        end
      end
      O_LOW: begin
        if (oc_q == OW'(EN_GAP - 1)) os_d = O_IDLE;
        else                         oc_d = oc_q + 1'b1;
      end
      default: os_d = O_IDLE;
    endcase
  end

  // FIFO: a full FIFO still accepts a push when the head leaves that cycle.
  always_comb begin
    full    = (cnt_q == CW'(FIFO_DEPTH));
    empty   = (cnt_q == '0);
    do_push = push && (!full || pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (do_push) begin
      mem_d[wr_q] = sh_q;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    if (do_push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && pop) cnt_d = cnt_q - 1'b1;
    if (push && !do_push) ovf_d = 1'b1;
  end

  // State registers; synchroniser flops reset to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      div_q  <= '0;
      rs_q   <= R_IDLE;
      sc_q   <= '0;
      bi_q   <= '0;
      sh_q   <= '0;
      ferr_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      os_q   <= O_IDLE;
      oc_q   <= '0;
      char_q <= '0;
      en_q   <= 1'b0;
    end else begin
      rx_m_q <= rx_m_d;
      rx_s_q <= rx_s_d;
      div_q  <= div_d;
      rs_q   <= rs_d;
      sc_q   <= sc_d;
      bi_q   <= bi_d;
      sh_q   <= sh_d;
      ferr_q <= ferr_d;
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      os_q   <= os_d;
      oc_q   <= oc_d;
      char_q <= char_d;
      en_q   <= en_d;
    end
  end

  assign char       = char_q;
  assign en         = en_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;

endmodule

// File: doc/uart_char_feeder.md
Name: uart_char_feeder

Overview:
Receives 8N1 serial bytes on a single RX pin and buffers them in a small FIFO. It replays each byte to the text-display stage as a stable `char` byte with a clean `en` pulse. Every pulse has a guaranteed low gap, so the display's rising-edge detector registers exactly one event per byte. It sits directly upstream of the VGA text renderer, and its `char`/`en` outputs connect straight to that block's `char`/`en` inputs.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, baud ticks per bit; fixed at 16.
- FIFO_DEPTH, 8, byte buffer depth; power of two, at least 2.
- EN_HOLD, 4, clk cycles that `en` stays high per byte; at least 1.
- EN_GAP, 4, minimum clk cycles `en` stays low after each pulse; at least 1.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high reset (already decided).
- rx, in, 1: serial input; idles high; asynchronous to clk.
- char, out, 8: byte presented downstream.
- en, out, 1: byte-valid pulse, active high.
- frame_err, out, 1: one-cycle pulse when a stop bit is bad.
- overflow, out, 1: sticky flag, set when a received byte is dropped because the FIFO is full.
- fifo_count, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (async):
  - All registers clear.
  - Outputs: `char`=0x00, `en`=0, `frame_err`=0, `overflow`=0, `fifo_count`=0.
  - Both RX synchroniser flops reset to 1; the receiver and output FSMs go to IDLE.
  - Reset asserted mid-frame or mid-pulse discards the partial byte and all FIFO contents.
- Input sync: `rx` passes through 2 flops (`rx_s`); all receive logic uses `rx_s` only.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation (default 651).
  - Counter runs 0..DIV-1; `tick` is high for one cycle when the counter equals DIV-1, then the counter wraps to 0.
  - Free-running.
- Receiver FSM (states IDLE, START, DATA, STOP; sample counter `sc` 0..15 advances on `tick`):
  - IDLE: when `rx_s`=0 on a tick, set `sc`=0 and go to START.
  - START: when `sc`=7, if `rx_s`=0 go to DATA with `sc`=0 and bit index 0. Otherwise it is a glitch: return to IDLE with no output.
  - DATA: every 16 ticks, at `sc`=7 relative to the bit start, shift `rx_s` into the shift register LSB-first. After bit 7 go to STOP.
  - STOP: at mid-bit (`sc`=7):
    - `rx_s`=1: push the byte into the FIFO.
    - `rx_s`=0: pulse `frame_err` for exactly one clk and discard the byte.
    - Either way, return to IDLE on the next cycle; no wait for the end of the stop bit.
- FIFO:
  - Circular buffer with rd/wr pointers and a count.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push when full with no pop that cycle: byte dropped, `overflow` set to 1, stays 1 until reset.
  - Push when full with a pop the same cycle: accepted.
  - `fifo_count` is registered and reflects the post-edge occupancy.
- Output FSM (states OIDLE, OHIGH, OLOW; counter `oc`):
  - OIDLE: if the FIFO is not empty, pop. On the same edge, load `char` with the head byte and set `en`=1, `oc`=0, and go to OHIGH. So `char` is valid in the same cycle `en` first reads high.
  - OHIGH: `oc` increments each cycle. When `oc`=EN_HOLD-1: `en`<=0, `oc`=0, go to OLOW.
  - OLOW: when `oc`=EN_GAP-1, go to OIDLE.
  - `char` holds its value from OHIGH entry until the next load, and never changes while `en`=1.
  - Per-byte period is at least EN_HOLD+EN_GAP+1 clk.
- Throughput: with default parameters the output drains far faster than the line rate, so the FIFO never overflows in normal use. Overflow is reachable only with an enlarged EN_HOLD/EN_GAP.
- All outputs are registered; there is no combinational path from `rx` to any output.

Test Plan (benches override CLK_FREQ=1600000, BAUD=10000, so DIV=10 and one bit = 160 clk):
- Single byte: send 0x41 framed correctly → exactly one `en` high for 4 clk, `char`=0x41 in all 4 cycles, then `en` low for at least 4 clk; `fifo_count` returns to 0; `frame_err` and `overflow` stay 0.
- Back-to-back: send 0x48, 0x69, 0x0D with no idle between frames → three separate `en` pulses in order with `char` 0x48, 0x69, 0x0D; each pulse is preceded by at least 4 low cycles.
- Framing error: send 0x55 with stop bit = 0 → `frame_err` high for exactly 1 clk, no `en` pulse, `fifo_count` stays 0. A following valid 0x31 is received correctly.
- Glitch: drive `rx` low for 50 clk (5 ticks), then high → receiver returns to IDLE, no `en`, no `frame_err`. A following 0x7A decodes correctly.
- Overflow: FIFO_DEPTH=4, EN_HOLD=20000; send 6 bytes 0x30..0x35 back-to-back:
  - The first byte is popped at once and 4 more are buffered, so 5 bytes total are retained.
  - The 6th byte is dropped and `overflow`=1 thereafter.
  - Output sequence is 0x30..0x34.
- Reset mid-frame: assert `reset` for 3 clk during bit 4 of a frame with 2 bytes already queued → `en`=0, `char`=0x00, `fifo_count`=0. No stale output after release. The next complete frame 0x42 yields `char`=0x42.
